alsu_out_serializer: RTL

ALSU_OUT_SERIALIZER -- requirements
Module: alsu_out_serializer

---
 rtl/alsu_out_serializer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alsu_out_serializer.sv
// Buffers ALSU result words in a small FIFO and sends each as a framed,
// parity-protected serial stream on tx: start, 6 data LSB-first, err, parity, stop.
module alsu_out_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BIT_CYCLES = 2,
    parameter string       PARITY     = "EVEN"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [5:0]                    in_data,
    input  logic                          in_err,
    input  logic                          ovf_clr,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CYC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned WORD_W = 7;
    localparam int unsigned BIT_W  = 3;
    localparam logic        ODD_PAR = (PARITY == "ODD");

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ERR,
        PAR,
        STOP
    } state_t;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              push_c, drop_c, pop_c;
    logic [WORD_W-1:0] head_c;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q;
    logic              bit_done_c;

    // Room is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign in_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    assign push_c     = in_valid & in_ready;
    assign drop_c     = in_valid & ~in_ready;
    assign head_c     = mem[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx         = tx_q;
    assign busy       = busy_q;

    // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop_c)       overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= {in_err, in_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bit_done_c = (cyc_q == CYC_W'(BIT_CYCLES - 1));

    // tx_d carries the level of the state being entered, so tx lines up with state_q.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;

        if (state_q != IDLE) begin
            cyc_d = bit_done_c ? '0 : cyc_q + CYC_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    sh_d    = head_c;
                    par_d   = (^head_c) ^ ODD_PAR;
                    state_d = START;
                    cyc_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done_c) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    sh_d = {1'b0, sh_q[WORD_W-1:1]};
                    tx_d = sh_q[1];
                    if (bit_q == BIT_W'(5)) begin
                        state_d = ERR;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ERR: begin
                if (bit_done_c) begin
                    state_d = PAR;
                    tx_d    = par_q;
                end
            end
            PAR: begin
                if (bit_done_c) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done_c) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule
